// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and sequencing controller for a 5-stage pipeline (F, D, E, M, W).
//
// Purpose
//   - Selects forwarding sources for the two execute-stage operands.
//   - Detects load-use hazards and inserts a single bubble.
//   - Flushes decode/execute on a taken branch or jump.
//   - Freezes the pipeline while a variable-latency data memory completes.
//     A per-access timeout forces release and sets a sticky error flag.
//   - Keeps saturating counters of stall cycles and flush cycles.
//
// Memory handshake
//   memReq_M is the request strobe and memReady_M is the completion.
//   The access finishes in the first cycle where memReq_M and memReady_M
//   are both high. While the FSM is in WAIT, memReq_M stays high until
//   one of these happens:
//     - the access completes,
//     - the timeout releases the pipeline,
//     - reset abandons the access.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   Rs1_D, Rs2_D             source registers of the instruction in decode
//   Rs1_E, Rs2_E, Rd_E       source and destination registers in execute
//   resultSrc_E              00 ALU, 01 load, 10 PC+4
//   Rd_M, regWrite_M         destination and write enable in memory
//   Rd_W, regWrite_W         destination and write enable in writeback
//   PCsrc_E                  taken branch or jump resolved in execute
//   memAccess_M, memReady_M  memory-stage load/store and memory completion
//   forwardA_E, forwardB_E   operand selects: 00 regfile, 10 ALUResult_M, 01 result_W
//   stall_F/D/E/M            hold the stage register
//   flush_D/E/W              load a bubble into the stage register
//   memReq_M                 request strobe to the data memory
//   memErr                   sticky; set when a memory access timed out
//   stallCycles, flushCount  saturating performance counters
//   fsm_state                current wait-state FSM state (0 IDLE, 1 WAIT)
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       resultSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic             regWrite_M,
  input  logic [4:0]       Rd_W,
  input  logic             regWrite_W,
  input  logic             PCsrc_E,
  input  logic             memAccess_M,
  input  logic             memReady_M,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic             memReq_M,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount,
  output logic             fsm_state
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           ms;         // memory stall this cycle
  logic           lu;         // load-use hazard this cycle
  logic           wait_done;  // WAIT has spent its full timeout budget

  assign fsm_state = state;
  assign wait_done = (wait_cnt == WCW'(MEM_TIMEOUT));

  // M has priority over W because it holds the younger value.
  // Register x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    forwardA_E = fwd_sel(Rs1_E, Rd_M, regWrite_M, Rd_W, regWrite_W);
    forwardB_E = fwd_sel(Rs2_E, Rd_M, regWrite_M, Rd_W, regWrite_W);
  end

  // A load or a PC+4 result is not ready for forwarding out of execute.
  assign lu = (resultSrc_E != 2'b00) && (Rd_E != 5'd0) &&
              ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // The first stalled cycle of an access is spent in IDLE.
  // This is why WAIT releases once wait_cnt reaches MEM_TIMEOUT.
  always_comb begin
    ms = 1'b0;
    case (state)
      IDLE:    ms = memAccess_M && !memReady_M;
      WAIT:    ms = !memReady_M && !wait_done;
      default: ms = 1'b0;
    endcase
  end

  // While the memory stall is active, any branch waiting in E stays there.
  // Its flush is applied in the release cycle.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_W  = 1'b0;
    memReq_M = 1'b0;
    if (!rst) begin
      memReq_M = (state == WAIT) || memAccess_M;
      if (ms) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (PCsrc_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (lu) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      memErr      <= 1'b0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (stall_F && (stallCycles != '1)) begin
        stallCycles <= stallCycles + CNT_W'(1);
      end
      if (PCsrc_E && !ms && (flushCount != '1)) begin
        flushCount <= flushCount + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (memAccess_M && !memReady_M) begin
            state    <= WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        WAIT: begin
          if (memReady_M) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_done) begin
            state    <= IDLE;
            wait_cnt <= '0;
            memErr   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl.
// A rule-level model is checked against every output on each falling edge.
// The directed sections add literal expectations computed by hand.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0]       resultSrc_E;
  logic             regWrite_M, regWrite_W, PCsrc_E, memAccess_M, memReady_M;
  logic [1:0]       forwardA_E, forwardB_E;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic             memReq_M, memErr, fsm_state;
  logic [CNT_W-1:0] stallCycles, flushCount;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .resultSrc_E(resultSrc_E), .Rd_M(Rd_M), .regWrite_M(regWrite_M),
    .Rd_W(Rd_W), .regWrite_W(regWrite_W), .PCsrc_E(PCsrc_E),
    .memAccess_M(memAccess_M), .memReady_M(memReady_M),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .memReq_M(memReq_M), .memErr(memErr),
    .stallCycles(stallCycles), .flushCount(flushCount), .fsm_state(fsm_state)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks two things about the memory access:
  //   - m_in_access: the access is still outstanding.
  //   - m_age: how many cycles it has already been stalled.
  bit                 m_in_access = 1'b0;
  int                 m_age = 0;
  bit                 m_err = 1'b0;
  logic [CNT_W-1:0]   m_stall = '0;
  logic [CNT_W-1:0]   m_flush = '0;
  logic [2*CNT_W-1:0] exp_q[$];

  function automatic bit model_ms();
    if (!m_in_access) return memAccess_M && !memReady_M;
    return !memReady_M && (m_age < MEM_TIMEOUT);
  endfunction

  function automatic bit model_lu();
    return (resultSrc_E != 2'b00) && (Rd_E != 0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (regWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (regWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input bit en);
    if (en && v != {CNT_W{1'b1}}) return v + 1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_in_access <= 1'b0;
      m_age       <= 0;
      m_err       <= 1'b0;
      m_stall     <= '0;
      m_flush     <= '0;
      exp_q.push_back('0);
    end else begin
      m_stall <= sat_inc(m_stall, model_ms() || (!PCsrc_E && model_lu()));
      m_flush <= sat_inc(m_flush, PCsrc_E && !model_ms());
      exp_q.push_back({sat_inc(m_flush, PCsrc_E && !model_ms()),
                       sat_inc(m_stall, model_ms() || (!PCsrc_E && model_lu()))});
      if (model_ms()) begin
        m_in_access <= 1'b1;
        m_age       <= m_age + 1;
      end else begin
        if (m_in_access && !memReady_M) m_err <= 1'b1;
        m_in_access <= 1'b0;
        m_age       <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("forwardA_E", forwardA_E, model_fwd(Rs1_E));
      check("forwardB_E", forwardB_E, model_fwd(Rs2_E));
      check("stall_F", stall_F, !rst && (model_ms() || (!PCsrc_E && model_lu())));
      check("stall_D", stall_D, !rst && (model_ms() || (!PCsrc_E && model_lu())));
      check("stall_E", stall_E, !rst && model_ms());
      check("stall_M", stall_M, !rst && model_ms());
      check("flush_W", flush_W, !rst && model_ms());
      check("flush_D", flush_D, !rst && !model_ms() && PCsrc_E);
      check("flush_E", flush_E, !rst && !model_ms() && (PCsrc_E || model_lu()));
      check("memReq_M", memReq_M, !rst && (m_in_access || memAccess_M));
      check("memErr", memErr, m_err);
      check("fsm_state", fsm_state, m_in_access);
      if (exp_q.size() > 0) begin
        logic [2*CNT_W-1:0] e;
        e = exp_q.pop_front();
        check("stallCycles", stallCycles, e[CNT_W-1:0]);
        check("flushCount", flushCount, e[2*CNT_W-1:CNT_W]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; resultSrc_E = 2'b00;
    Rd_M = 0; regWrite_M = 0; Rd_W = 0; regWrite_W = 0;
    PCsrc_E = 0; memAccess_M = 0; memReady_M = 1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    quiet();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n_sm, n_fw, n_fd;
    rst = 1'b1;
    quiet();
    @(posedge clk);
    #1;
    check_en = 1'b1;
    next_cycle();
    rst = 1'b0;
    sample();
    check("reset stallCycles", stallCycles, 0);
    check("reset flushCount", flushCount, 0);
    check("reset memErr", memErr, 0);
    check("reset stall_F", stall_F, 0);

    // addi x5 ; add x6,x5,x5 back-to-back
    next_cycle();
    Rd_M = 5; regWrite_M = 1; Rs1_E = 5; Rs2_E = 5;
    sample();
    check("b2b forwardA", forwardA_E, 2'b10);
    check("b2b forwardB", forwardB_E, 2'b10);
    // one-instruction gap: producer now in W
    next_cycle();
    Rd_M = 7; regWrite_M = 1; Rd_W = 5; regWrite_W = 1;
    sample();
    check("gap forwardA", forwardA_E, 2'b01);
    check("gap forwardB", forwardB_E, 2'b01);
    // M and W both hit: M wins
    next_cycle();
    Rd_M = 5;
    sample();
    check("prio forwardA", forwardA_E, 2'b10);

    // lw x5 in E, add x6,x5,x0 in D
    next_cycle();
    quiet();
    resultSrc_E = 2'b01; Rd_E = 5; Rs1_D = 5; Rs2_D = 0;
    sample();
    check("lu stall_F", stall_F, 1);
    check("lu flush_E", flush_E, 1);
    // bubble in E, lw in M
    next_cycle();
    resultSrc_E = 2'b00; Rd_E = 0; Rd_M = 5; regWrite_M = 1;
    sample();
    check("lu released stall_F", stall_F, 0);
    // add in E, bubble in M, lw in W
    next_cycle();
    Rs1_E = 5; Rs2_E = 0; Rd_M = 0; regWrite_M = 0; Rd_W = 5; regWrite_W = 1;
    Rs1_D = 0;
    sample();
    check("lu forwardA", forwardA_E, 2'b01);

    // lw x0 feeding a reader of x0; x0 write in M
    next_cycle();
    quiet();
    resultSrc_E = 2'b01; Rd_E = 0; Rs1_D = 0; Rd_M = 0; regWrite_M = 1; Rs1_E = 0;
    sample();
    check("x0 no stall", stall_F, 0);
    check("x0 forwardA", forwardA_E, 2'b00);

    // branch coincident with load-use
    do_reset();
    resultSrc_E = 2'b01; Rd_E = 9; Rs2_D = 9; PCsrc_E = 1;
    sample();
    check("br+lu flush_D", flush_D, 1);
    check("br+lu flush_E", flush_E, 1);
    check("br+lu stall_F", stall_F, 0);
    next_cycle();
    quiet();
    sample();
    check("br+lu flushCount", flushCount, 1);

    // memory ready after 3 cycles, branch held in E
    do_reset();
    n_sm = 0; n_fw = 0; n_fd = 0;
    memAccess_M = 1; memReady_M = 0; PCsrc_E = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memReady_M = 1;
      sample();
      if (stall_M) n_sm++;
      if (flush_W) n_fw++;
      if (flush_D) n_fd++;
      if (i == 3) check("mem release flush_D", flush_D, 1);
      next_cycle();
    end
    quiet();
    sample();
    check("mem3 stall_M cycles", n_sm, 3);
    check("mem3 flush_W cycles", n_fw, 3);
    check("mem3 flush_D cycles", n_fd, 1);
    check("mem3 stallCycles", stallCycles, 3);
    check("mem3 flushCount", flushCount, 1);

    // timeout: memory never ready
    do_reset();
    memAccess_M = 1; memReady_M = 0;
    n_sm = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (!stall_M) break;
      n_sm++;
      next_cycle();
    end
    check("timeout stall_M cycles", n_sm, MEM_TIMEOUT);
    check("timeout memErr in release", memErr, 0);
    next_cycle();
    quiet();
    sample();
    check("timeout memErr", memErr, 1);
    check("timeout stallCycles", stallCycles, MEM_TIMEOUT);
    next_cycle();
    next_cycle();
    sample();
    check("memErr sticky", memErr, 1);

    // reset in the middle of WAIT
    next_cycle();
    memAccess_M = 1; memReady_M = 0;
    for (int i = 0; i < 5; i++) next_cycle();
    rst = 1;
    sample();
    check("rst stall_M", stall_M, 0);
    check("rst memReq_M", memReq_M, 0);
    next_cycle();
    rst = 0;
    quiet();
    sample();
    check("post-rst memErr", memErr, 0);
    check("post-rst fsm_state", fsm_state, 0);
    check("post-rst stallCycles", stallCycles, 0);

    // single-cycle memory: ready tied high
    memReady_M = 1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      memAccess_M = i[0];
      sample();
      check("1cyc stall_M", stall_M, 0);
    end

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: simulation limit reached, expected finish earlier");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
